// File: rtl/uart_rx_ascii_pkg.sv
// Shared definitions for the UART ASCII receiver: FSM states, oversampling
// constants and the 3-sample majority vote.
package uart_rx_ascii_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int unsigned OVERSAMPLE    = 16;
  localparam logic [3:0]  SAMPLE_TICK_0 = 4'd7;
  localparam logic [3:0]  SAMPLE_TICK_1 = 4'd8;
  localparam logic [3:0]  SAMPLE_TICK_2 = 4'd9;
  localparam logic [3:0]  LAST_TICK     = 4'd15;
  localparam logic [6:0]  ASCII_MASK    = 7'h7F;

  function automatic logic vote3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversampling tick generator: one-cycle strobe every CLK_FREQ/(BAUD*OVERSAMPLE)
// clocks, restartable via clr so bit timing can align to a start edge.
module baud_tick_gen #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/uart_rx_ascii.sv
// 8N1 UART receiver with 16x oversampling and majority vote; delivers 7-bit
// ASCII codes with a one-cycle valid strobe and flags rejected frames.
module uart_rx_ascii #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = uart_rx_ascii_pkg::OVERSAMPLE
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Rx,
  output logic [6:0] RxData,
  output logic       RxValid,
  output logic       RxErr,
  output logic       Busy
);

  import uart_rx_ascii_pkg::*;

  rx_state_t  state, state_next;
  logic       rx_m, rx_s;
  logic       tick, clr;
  logic [3:0] tick_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic [2:0] smp;
  logic       bit_vote, stop_ok, accept, reject;

  baud_tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .CLK (CLK),
    .RST (RST),
    .clr (clr),
    .tick(tick)
  );

  assign bit_vote = vote3(smp);
  // Stop is judged at mid-bit, before the third sample exists: both samples
  // taken so far (tick 7 and the live tick-8 value) must be high.
  assign stop_ok  = smp[0] & rx_s;

  always_comb begin
    state_next = state;
    clr        = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          clr        = 1'b1;
        end
      end
      START: begin
        if (tick && tick_cnt == LAST_TICK) state_next = bit_vote ? IDLE : DATA;
      end
      DATA: begin
        if (tick && tick_cnt == LAST_TICK && bit_idx == 3'd7) state_next = STOP;
      end
      STOP: begin
        if (tick && tick_cnt == SAMPLE_TICK_1) begin
          if (stop_ok) begin
            state_next = IDLE;
            accept     = !shreg[7];
            reject     = shreg[7];
          end else begin
            state_next = BREAK;
            reject     = 1'b1;
          end
        end
      end
      BREAK: begin
        if (tick && rx_s && tick_cnt == LAST_TICK) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      smp      <= '0;
      RxData   <= '0;
      RxValid  <= 1'b0;
      RxErr    <= 1'b0;
    end else begin
      rx_m    <= Rx;
      rx_s    <= rx_m;
      state   <= state_next;
      RxValid <= accept;
      RxErr   <= reject;
      if (accept) RxData <= shreg[6:0] & ASCII_MASK;

      // In BREAK the tick counter doubles as the consecutive-high counter.
      if (clr || (state != BREAK && state_next == BREAK)) begin
        tick_cnt <= '0;
      end else if (tick) begin
        if (state == BREAK && !rx_s) tick_cnt <= '0;
        else                         tick_cnt <= tick_cnt + 4'd1;
      end

      if (tick) begin
        if (tick_cnt == SAMPLE_TICK_0) smp[0] <= rx_s;
        if (tick_cnt == SAMPLE_TICK_1) smp[1] <= rx_s;
        if (tick_cnt == SAMPLE_TICK_2) smp[2] <= rx_s;
      end

      if (clr) begin
        bit_idx <= '0;
      end else if (state == DATA && tick && tick_cnt == LAST_TICK) begin
        shreg   <= {bit_vote, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ascii.sv
// Directed and randomized frames against a frame-level reference model of
// the ASCII receiver.
module tb_uart_rx_ascii;

  localparam int unsigned CLK_FREQ = 1_280_000;
  localparam int unsigned BAUD     = 10_000;
  localparam int          BIT      = CLK_FREQ / BAUD;
  localparam int          TICK     = BIT / 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [6:0] rx_data;
  logic       rx_valid, rx_err, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  logic [6:0] got_q[$];
  logic [6:0] model_data = 7'h00;

  always #5 clk = ~clk;

  uart_rx_ascii #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .Rx     (rx),
    .RxData (rx_data),
    .RxValid(rx_valid),
    .RxErr  (rx_err),
    .Busy   (busy)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      got_q.push_back(rx_data);
    end
    if (rx_err) err_cnt++;
    if (rx_valid || rx_err) begin
      n_cmp++;
      assert (!(rx_valid && rx_err)) else begin
        n_bad++;
        $error("FAIL pulse_excl: observed valid=%0b err=%0b expected not both", rx_valid, rx_err);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_clks);
    rx = 1'b0;
    repeat (bit_clks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bit_clks) @(negedge clk);
    end
    rx = stop;
    repeat (bit_clks) @(negedge clk);
    if (!stop) begin
      repeat (bit_clks) @(negedge clk);
      rx = 1'b1;
      repeat (3 * bit_clks) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  // Reference: a frame is accepted only with a high stop bit and bit7 clear.
  task automatic check_frame(input string tag, input logic [7:0] b, input logic stop,
                             input int v0, input int e0);
    int exp_v;
    exp_v = (stop && !b[7]) ? 1 : 0;
    if (exp_v == 1) model_data = b[6:0];
    check({tag, "_valid"}, valid_cnt - v0, exp_v);
    check({tag, "_err"}, err_cnt - e0, 1 - exp_v);
    check({tag, "_data"}, {25'd0, rx_data}, {25'd0, model_data});
  endtask

  task automatic check_seq(input string tag, input int q0, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] exp [3];
    exp[0] = b0; exp[1] = b1; exp[2] = b2;
    for (int i = 0; i < 3; i++) begin
      if (got_q.size() > q0 + i) check(tag, {25'd0, got_q[q0 + i]}, {25'd0, exp[i][6:0]});
      else                       check(tag, 32'hFFFF_FFFF, {25'd0, exp[i][6:0]});
    end
    model_data = b2[6:0];
  endtask

  initial begin
    int v0, e0, q0, gap;
    logic [7:0] b;
    logic       stop;
    logic [7:0] b45;

    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_data", {25'd0, rx_data}, 32'h0);
    check("rst_valid", {31'd0, rx_valid}, 32'h0);
    check("rst_err", {31'd0, rx_err}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    repeat (2 * BIT) @(negedge clk);

    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h41, 1'b1, BIT);
    check_frame("char_A", 8'h41, 1'b1, v0, e0);
    check("char_A_busy", {31'd0, busy}, 32'h0);
    repeat (BIT) @(negedge clk);

    v0 = valid_cnt; e0 = err_cnt;
    rx = 1'b0;
    repeat (3 * TICK) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("false_start_busy_hi", {31'd0, busy}, 32'h1);
    repeat (2 * BIT) @(negedge clk);
    check("false_start_busy_lo", {31'd0, busy}, 32'h0);
    check("false_start_valid", valid_cnt - v0, 0);
    check("false_start_err", err_cnt - e0, 0);

    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h53, 1'b0, BIT);
    check_frame("bad_stop", 8'h53, 1'b0, v0, e0);
    check("bad_stop_busy", {31'd0, busy}, 32'h0);
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h4F, 1'b1, BIT);
    check_frame("after_break", 8'h4F, 1'b1, v0, e0);
    repeat (BIT) @(negedge clk);

    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'hC1, 1'b1, BIT);
    check_frame("non_ascii", 8'hC1, 1'b1, v0, e0);
    repeat (BIT) @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      int bc;
      bc = (k == 0) ? BIT : (k == 1) ? BIT - 3 : BIT + 3;
      v0 = valid_cnt; e0 = err_cnt; q0 = got_q.size();
      send_frame(8'h53, 1'b1, bc);
      send_frame(8'h4F, 1'b1, bc);
      send_frame(8'h53, 1'b1, bc);
      check("sos_count", valid_cnt - v0, 3);
      check("sos_err", err_cnt - e0, 0);
      check_seq("sos_data", q0, 8'h53, 8'h4F, 8'h53);
      repeat (BIT) @(negedge clk);
    end

    b45 = 8'h45;
    v0 = valid_cnt; e0 = err_cnt;
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b45[i];
      repeat (BIT) @(negedge clk);
    end
    rx = b45[4];
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'h0);
    check("midrst_valid", {31'd0, rx_valid}, 32'h0);
    check("midrst_err", {31'd0, rx_err}, 32'h0);
    check("midrst_data", {25'd0, rx_data}, 32'h0);
    model_data = 7'h00;
    rst = 1'b0;
    rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check("midrst_no_valid", valid_cnt - v0, 0);
    check("midrst_no_err", err_cnt - e0, 0);
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h54, 1'b1, BIT);
    check_frame("after_rst", 8'h54, 1'b1, v0, e0);
    repeat (BIT) @(negedge clk);

    for (int n = 0; n < 20; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      gap  = $urandom_range(0, 2);
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(b, stop, BIT);
      check_frame("rand", b, stop, v0, e0);
      rx = 1'b1;
      repeat (gap * BIT) @(negedge clk);
    end

    repeat (BIT) @(negedge clk);
    check("final_busy", {31'd0, busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
